// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard sequencer
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    // Canonical RISC-V NOP (addi x0,x0,0) loaded by the datapath on bubble/flush
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDUSE   = 2'd1,
        ST_MEMWAIT = 2'd2,
        ST_FLUSH   = 2'd3
    } hz_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_bubble;
        logic exmem_en;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN    = hz_ctrl_t'(5'b11001);
    localparam hz_ctrl_t CTRL_STALL  = hz_ctrl_t'(5'b00011);
    localparam hz_ctrl_t CTRL_FREEZE = hz_ctrl_t'(5'b00000);
    localparam hz_ctrl_t CTRL_FLUSH  = hz_ctrl_t'(5'b11111);
    localparam hz_ctrl_t CTRL_RESET  = hz_ctrl_t'(5'b00111);

endpackage

// File: rtl/hazard_stall_controller_if.sv
// rtl/hazard_stall_controller_if.sv - ID/EX hazard inputs and pipeline control outputs
interface hazard_stall_controller_if #(
    parameter int CNT_W = 16
);
    import hazard_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1_a;
    logic [REG_ADDR_W-1:0] id_rs2_a;
    logic [REG_ADDR_W-1:0] id_rs1_b;
    logic [REG_ADDR_W-1:0] id_rs2_b;
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] idex_rd1;
    logic [REG_ADDR_W-1:0] idex_rd2;
    logic                  idex_memrd1;
    logic                  idex_memrd2;
    logic                  br_taken;
    logic                  mem_busy;
    logic                  pc_en;
    logic                  ifid_en;
    logic                  ifid_flush;
    logic                  idex_bubble;
    logic                  exmem_en;
    logic [1:0]            state_o;
    logic [CNT_W-1:0]      stall_cnt;

    modport slave (
        input  id_rs1_a, id_rs2_a, id_rs1_b, id_rs2_b, id_valid,
        input  idex_rd1, idex_rd2, idex_memrd1, idex_memrd2,
        input  br_taken, mem_busy,
        output pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
        output state_o, stall_cnt
    );

    modport master (
        output id_rs1_a, id_rs2_a, id_rs1_b, id_rs2_b, id_valid,
        output idex_rd1, idex_rd2, idex_memrd1, idex_memrd2,
        output br_taken, mem_busy,
        input  pc_en, ifid_en, ifid_flush, idex_bubble, exmem_en,
        input  state_o, stall_cnt
    );

endinterface

// File: rtl/hazard_detect.sv
// rtl/hazard_detect.sv - combinational load-use compare, 4 ID sources x 2 EX load destinations
module hazard_detect
    import hazard_pkg::*;
#(
    parameter int IGNORE_R0 = 0
) (
    input  logic [REG_ADDR_W-1:0] rs1_a,
    input  logic [REG_ADDR_W-1:0] rs2_a,
    input  logic [REG_ADDR_W-1:0] rs1_b,
    input  logic [REG_ADDR_W-1:0] rs2_b,
    input  logic                  valid,
    input  logic [REG_ADDR_W-1:0] rd1,
    input  logic [REG_ADDR_W-1:0] rd2,
    input  logic                  memrd1,
    input  logic                  memrd2,
    output logic                  ldu
);

    function automatic logic src_hit(input logic [REG_ADDR_W-1:0] src);
        logic hit;
        hit = (memrd1 && (src == rd1)) || (memrd2 && (src == rd2));
        if ((IGNORE_R0 != 0) && (src == '0)) begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    always_comb begin
        ldu = valid && (src_hit(rs1_a) || src_hit(rs2_a) ||
                        src_hit(rs1_b) || src_hit(rs2_b));
    end

endmodule

// File: rtl/hazard_stall_controller.sv
// rtl/hazard_stall_controller.sv - stall/flush/freeze sequencer; HAZARD_STALL_CNT_EN adds a saturating stall counter
module hazard_stall_controller
    import hazard_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int IGNORE_R0    = 0,
    parameter int CNT_W        = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    hazard_stall_controller_if.slave  hz
);

    // The branch cycle in RUN is the first flush cycle, so FLUSH holds for FLUSH_CYCLES-1 more
    localparam logic       GO_FLUSH   = (FLUSH_CYCLES > 1);
    localparam logic [1:0] FLUSH_LOAD = GO_FLUSH ? 2'(FLUSH_CYCLES - 2) : 2'd0;

    hz_state_t state, state_n;
    logic [1:0] fcnt, fcnt_n;
    hz_ctrl_t   ctrl;
    logic       ldu;

    hazard_detect #(.IGNORE_R0(IGNORE_R0)) u_detect (
        .rs1_a  (hz.id_rs1_a),
        .rs2_a  (hz.id_rs2_a),
        .rs1_b  (hz.id_rs1_b),
        .rs2_b  (hz.id_rs2_b),
        .valid  (hz.id_valid),
        .rd1    (hz.idex_rd1),
        .rd2    (hz.idex_rd2),
        .memrd1 (hz.idex_memrd1),
        .memrd2 (hz.idex_memrd2),
        .ldu    (ldu)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
            fcnt  <= 2'd0;
        end else begin
            state <= state_n;
            fcnt  <= fcnt_n;
        end
    end

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        ctrl    = CTRL_RUN;
        case (state)
            ST_RUN, ST_LDUSE: begin
                state_n = ST_RUN;
                if (hz.mem_busy) begin
                    ctrl    = CTRL_FREEZE;
                    state_n = ST_MEMWAIT;
                end else if (hz.br_taken) begin
                    ctrl = CTRL_FLUSH;
                    if (GO_FLUSH) begin
                        state_n = ST_FLUSH;
                        fcnt_n  = FLUSH_LOAD;
                    end
                end else if (ldu) begin
                    ctrl    = CTRL_STALL;
                    state_n = ST_LDUSE;
                end
            end
            ST_MEMWAIT: begin
                ctrl = CTRL_FREEZE;
                if (!hz.mem_busy) begin
                    state_n = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (hz.mem_busy) begin
                    ctrl = CTRL_FREEZE;
                end else begin
                    ctrl = CTRL_FLUSH;
                    if (fcnt == 2'd0) begin
                        state_n = ST_RUN;
                    end else begin
                        fcnt_n = fcnt - 2'd1;
                    end
                end
            end
            default: state_n = ST_RUN;
        endcase
        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    assign hz.pc_en       = ctrl.pc_en;
    assign hz.ifid_en     = ctrl.ifid_en;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_bubble = ctrl.idex_bubble;
    assign hz.exmem_en    = ctrl.exmem_en;
    assign hz.state_o     = state;

`ifdef HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (!ctrl.pc_en && (cnt != {CNT_W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign hz.stall_cnt = cnt;
`else
    assign hz.stall_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb/tb_hazard_stall_controller.sv - scoreboard bench for hazard_stall_controller (two parameterisations)
module tb_hazard_stall_controller;
    import hazard_pkg::*;

    localparam logic [4:0] NORM  = 5'b11001;
    localparam logic [4:0] STALL = 5'b00011;
    localparam logic [4:0] FRZ   = 5'b00000;
    localparam logic [4:0] FLS   = 5'b11111;
    localparam logic [4:0] RSTO  = 5'b00111;

    typedef enum {K_IDLE, K_LDU, K_LDU2, K_MB, K_BR, K_BR_LDU, K_MB_BR, K_RST, K_R0} kind_t;

    typedef struct {
        kind_t      kind;
        logic [4:0] ea;
        logic [1:0] sa;
        logic       cb;
        logic [4:0] eb;
        logic [1:0] sb;
    } row_t;

    typedef struct {
        logic [4:0] ctrl;
        logic [1:0] st;
        int         cnt;
        bit         cnt_ok;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    row_t rows[$];
    exp_t qa[$];
    exp_t qb[$];

    always #5 clk = ~clk;

    hazard_stall_controller_if #(.CNT_W(16)) ifa ();
    hazard_stall_controller_if #(.CNT_W(3))  ifb ();

    hazard_stall_controller #(.FLUSH_CYCLES(2), .IGNORE_R0(0), .CNT_W(16)) dut_a (
        .clk (clk), .rst (rst), .hz (ifa.slave)
    );
    hazard_stall_controller #(.FLUSH_CYCLES(1), .IGNORE_R0(1), .CNT_W(3)) dut_b (
        .clk (clk), .rst (rst), .hz (ifb.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add(input kind_t k, input logic [4:0] ea, input logic [1:0] sa,
                       input logic cb, input logic [4:0] eb, input logic [1:0] sb);
        row_t r;
        r.kind = k; r.ea = ea; r.sa = sa; r.cb = cb; r.eb = eb; r.sb = sb;
        rows.push_back(r);
    endtask

    // Default operands carry a slot-1 load-use match that only counts when id_valid=1
    task automatic drive(input kind_t k);
        logic [4:0] rs1a, rs2a, rs1b, rs2b, rd1, rd2;
        logic v, m1, m2, br, mb;
        rs1a = 5'd1; rs2a = 5'd2; rs1b = 5'd3; rs2b = 5'd5;
        rd1 = 5'd5; rd2 = 5'd7; m1 = 1'b1; m2 = 1'b1;
        v = 1'b0; br = 1'b0; mb = 1'b0; rst = 1'b0;
        case (k)
            K_LDU:    v = 1'b1;
            K_LDU2:   begin v = 1'b1; rs2b = 5'd4; rd2 = 5'd6; rs1a = 5'd6; end
            K_MB:     mb = 1'b1;
            K_BR:     br = 1'b1;
            K_BR_LDU: begin br = 1'b1; v = 1'b1; end
            K_MB_BR:  begin mb = 1'b1; br = 1'b1; end
            K_RST:    rst = 1'b1;
            K_R0:     begin v = 1'b1; rs1a = 5'd0; rs2a = 5'd1; rs1b = 5'd2; rs2b = 5'd3;
                            rd1 = 5'd9; m1 = 1'b0; rd2 = 5'd0; m2 = 1'b1; end
            default:  ;
        endcase
        ifa.id_rs1_a = rs1a; ifa.id_rs2_a = rs2a; ifa.id_rs1_b = rs1b; ifa.id_rs2_b = rs2b;
        ifa.id_valid = v; ifa.idex_rd1 = rd1; ifa.idex_rd2 = rd2;
        ifa.idex_memrd1 = m1; ifa.idex_memrd2 = m2; ifa.br_taken = br; ifa.mem_busy = mb;
        ifb.id_rs1_a = rs1a; ifb.id_rs2_a = rs2a; ifb.id_rs1_b = rs1b; ifb.id_rs2_b = rs2b;
        ifb.id_valid = v; ifb.idex_rd1 = rd1; ifb.idex_rd2 = rd2;
        ifb.idex_memrd1 = m1; ifb.idex_memrd2 = m2; ifb.br_taken = br; ifb.mem_busy = mb;
    endtask

    initial begin
        int   cnt_a, cnt_b;
        bit   ok_a, ok_b, cnt_on;
        exp_t e;

`ifdef HAZARD_STALL_CNT_EN
        cnt_on = 1'b1;
`else
        cnt_on = 1'b0;
`endif
        // Phase A: FLUSH_CYCLES=2 instance only
        add(K_RST, RSTO, 0, 0, 0, 0);   add(K_IDLE, NORM, 0, 0, 0, 0);
        add(K_LDU, STALL, 0, 0, 0, 0);  add(K_IDLE, NORM, 1, 0, 0, 0);
        add(K_IDLE, NORM, 0, 0, 0, 0);  add(K_MB, FRZ, 0, 0, 0, 0);
        add(K_MB, FRZ, 2, 0, 0, 0);     add(K_MB, FRZ, 2, 0, 0, 0);
        add(K_IDLE, FRZ, 2, 0, 0, 0);   add(K_IDLE, NORM, 0, 0, 0, 0);
        add(K_BR, FLS, 0, 0, 0, 0);     add(K_IDLE, FLS, 3, 0, 0, 0);
        add(K_IDLE, NORM, 0, 0, 0, 0);  add(K_BR_LDU, FLS, 0, 0, 0, 0);
        add(K_LDU, FLS, 3, 0, 0, 0);    add(K_IDLE, NORM, 0, 0, 0, 0);
        add(K_MB_BR, FRZ, 0, 0, 0, 0);  add(K_BR, FRZ, 2, 0, 0, 0);
        add(K_BR, FLS, 0, 0, 0, 0);     add(K_MB, FRZ, 3, 0, 0, 0);
        add(K_IDLE, FLS, 3, 0, 0, 0);   add(K_IDLE, NORM, 0, 0, 0, 0);
        add(K_BR, FLS, 0, 0, 0, 0);     add(K_RST, RSTO, 3, 0, 0, 0);
        add(K_IDLE, NORM, 0, 0, 0, 0);  add(K_LDU, STALL, 0, 0, 0, 0);
        add(K_LDU2, STALL, 1, 0, 0, 0); add(K_IDLE, NORM, 1, 0, 0, 0);
        add(K_IDLE, NORM, 0, 0, 0, 0);
        // Phase B: both instances; R0 handling, FLUSH_CYCLES=1, counter saturation
        add(K_RST, RSTO, 0, 1, RSTO, 0); add(K_R0, STALL, 0, 1, NORM, 0);
        add(K_IDLE, NORM, 1, 1, NORM, 0); add(K_IDLE, NORM, 0, 1, NORM, 0);
        add(K_BR, FLS, 0, 1, FLS, 0);    add(K_IDLE, FLS, 3, 1, NORM, 0);
        add(K_IDLE, NORM, 0, 1, NORM, 0); add(K_MB, FRZ, 0, 1, FRZ, 0);
        for (int i = 0; i < 8; i++) add(K_MB, FRZ, 2, 1, FRZ, 2);
        add(K_IDLE, FRZ, 2, 1, FRZ, 2);  add(K_IDLE, NORM, 0, 1, NORM, 0);
        add(K_IDLE, NORM, 0, 1, NORM, 0);

        drive(K_RST);
        repeat (2) @(posedge clk);
        cnt_a = 0; cnt_b = 0; ok_a = 1'b1; ok_b = 1'b1;

        for (int i = 0; i < rows.size(); i++) begin
            @(posedge clk);
            #1;
            drive(rows[i].kind);
            e.ctrl = rows[i].ea; e.st = rows[i].sa;
            e.cnt = cnt_on ? cnt_a : 0; e.cnt_ok = ok_a || !cnt_on;
            qa.push_back(e);
            if (rows[i].cb) begin
                e.ctrl = rows[i].eb; e.st = rows[i].sb;
                e.cnt = cnt_on ? cnt_b : 0; e.cnt_ok = ok_b || !cnt_on;
                qb.push_back(e);
            end
            if (rows[i].kind == K_RST) begin
                cnt_a = 0; cnt_b = 0; ok_a = 1'b1; ok_b = 1'b1;
            end else begin
                if (!rows[i].ea[4] && cnt_a < 65535) cnt_a++;
                if (!rows[i].cb) ok_b = 1'b0;
                else if (!rows[i].eb[4] && cnt_b < 7) cnt_b++;
            end

            @(negedge clk);
            e = qa.pop_front();
            check($sformatf("a%0d.ctrl", i),
                  {27'd0, ifa.pc_en, ifa.ifid_en, ifa.ifid_flush, ifa.idex_bubble, ifa.exmem_en},
                  {27'd0, e.ctrl});
            check($sformatf("a%0d.state", i), {30'd0, ifa.state_o}, {30'd0, e.st});
            if (e.cnt_ok) check($sformatf("a%0d.stall_cnt", i), {16'd0, ifa.stall_cnt}, e.cnt);
            if (rows[i].cb) begin
                e = qb.pop_front();
                check($sformatf("b%0d.ctrl", i),
                      {27'd0, ifb.pc_en, ifb.ifid_en, ifb.ifid_flush, ifb.idex_bubble, ifb.exmem_en},
                      {27'd0, e.ctrl});
                check($sformatf("b%0d.state", i), {30'd0, ifb.state_o}, {30'd0, e.st});
                if (e.cnt_ok) check($sformatf("b%0d.stall_cnt", i), {29'd0, ifb.stall_cnt}, e.cnt);
            end
        end

        check("queue_a_drained", qa.size(), 0);
        check("queue_b_drained", qb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
